// File: rtl/io_1ton_chk.sv
// io_1ton_chk: one-source message generator with NUM_SNK independent sink checkers.
// Optional feature macro IO_1TON_ERR_CNT_EN builds saturating 8-bit per-sink error counters.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module io_1ton_chk #(
  parameter int unsigned NUM_SNK      = 2,
  parameter int unsigned MIN_ADDR     = 1,
  parameter int unsigned ADDR_PER_SNK = 2,
  parameter int unsigned SRC_ID       = 9,
  parameter int unsigned ASZ          = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ          = `NS_DATA_SIZE,
  parameter int unsigned RSZ          = `NS_REDUN_SIZE
) (
  input  logic                   src0_clk,
  input  logic                   reset,
  output logic [ASZ-1:0]         o0_src,
  output logic [ASZ-1:0]         o0_dst,
  output logic [DSZ-1:0]         o0_dat,
  output logic [RSZ-1:0]         o0_red,
  output logic                   o0_req_out,
  input  logic                   o0_ack_in,
  input  logic [NUM_SNK*ASZ-1:0] i_src,
  input  logic [NUM_SNK*ASZ-1:0] i_dst,
  input  logic [NUM_SNK*DSZ-1:0] i_dat,
  input  logic [NUM_SNK*RSZ-1:0] i_red,
  input  logic [NUM_SNK-1:0]     i_req_in,
  output logic [NUM_SNK-1:0]     i_ack_out,
  output logic [NUM_SNK-1:0]     snk_err,
  output logic [NUM_SNK*8-1:0]   err_cnt,
  output logic [15:0]            msg_cnt
);

  localparam int unsigned IW       = (NUM_SNK > 1) ? $clog2(NUM_SNK) : 1;
  localparam int unsigned MAX_ADDR = MIN_ADDR + NUM_SNK * ADDR_PER_SNK - 1;
  localparam int unsigned VW       = 2 * ASZ + DSZ;

  localparam logic [2:0] S_DST  = 3'd0;
  localparam logic [2:0] S_DAT  = 3'd1;
  localparam logic [2:0] S_RED  = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [1:0] K_IDLE  = 2'd0;
  localparam logic [1:0] K_LATCH = 2'd1;
  localparam logic [1:0] K_CHECK = 2'd2;
  localparam logic [1:0] K_ACK   = 2'd3;

  // Redundancy is an XOR fold of {src, dst, dat} into RSZ bits, LSB-aligned.
  function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] src,
                                                input logic [ASZ-1:0] dst,
                                                input logic [DSZ-1:0] dat);
    logic [VW-1:0]  v;
    logic [RSZ-1:0] r;
    v = {src, dst, dat};
    r = '0;
    for (int i = 0; i < VW; i++) begin
      r[i % RSZ] = r[i % RSZ] ^ v[i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Source side
  // ---------------------------------------------------------------------------
  logic [2:0]     src_state_q, src_state_d;
  logic [ASZ-1:0] addr_q;
  logic [DSZ-1:0] seq_q [NUM_SNK];
  logic [IW-1:0]  src_idx;

  assign o0_src     = ASZ'(SRC_ID);
  assign o0_req_out = (src_state_q == S_REQ);
  assign src_idx    = IW'((32'(o0_dst) - MIN_ADDR) / ADDR_PER_SNK);

  always_comb begin
    src_state_d = src_state_q;
    case (src_state_q)
      S_DST:   src_state_d = S_DAT;
      S_DAT:   src_state_d = S_RED;
      S_RED:   src_state_d = S_REQ;
      S_REQ:   if (o0_ack_in) src_state_d = S_WAIT;
      S_WAIT:  if (!o0_ack_in) src_state_d = S_DST;
      default: src_state_d = S_DST;
    endcase
  end

  always_ff @(posedge src0_clk or negedge reset) begin
    if (!reset) begin
      src_state_q <= S_DST;
      addr_q      <= ASZ'(MIN_ADDR);
      o0_dst      <= ASZ'(MIN_ADDR);
      o0_dat      <= '0;
      o0_red      <= '0;
      msg_cnt     <= '0;
      for (int i = 0; i < NUM_SNK; i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      src_state_q <= src_state_d;
      case (src_state_q)
        S_DST: begin
          o0_dst <= addr_q;
          addr_q <= (addr_q == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : addr_q + 1'b1;
        end
        S_DAT: begin
          o0_dat          <= seq_q[src_idx];
          seq_q[src_idx]  <= seq_q[src_idx] + 1'b1;
        end
        S_RED: o0_red <= calc_redun(ASZ'(SRC_ID), o0_dst, o0_dat);
        S_REQ: if (o0_ack_in) msg_cnt <= msg_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sink checkers, one independent FSM per sink
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SNK; k++) begin : g_snk
    localparam int unsigned LO = MIN_ADDR + k * ADDR_PER_SNK;
    localparam int unsigned HI = LO + ADDR_PER_SNK - 1;

    logic [1:0]     st_q, st_d;
    logic [ASZ-1:0] src_q, dst_q;
    logic [DSZ-1:0] dat_q, exp_q;
    logic [RSZ-1:0] red_q;
    logic           err_q;
    logic           chk_err;

    assign i_ack_out[k] = (st_q == K_ACK);
    assign snk_err[k]   = err_q;

    always_comb begin
      st_d = st_q;
      case (st_q)
        K_IDLE:  if (i_req_in[k] && !i_ack_out[k]) st_d = K_LATCH;
        K_LATCH: st_d = K_CHECK;
        K_CHECK: st_d = K_ACK;
        K_ACK:   if (!i_req_in[k]) st_d = K_IDLE;
        default: st_d = K_IDLE;
      endcase
    end

    always_comb begin
      chk_err = (32'(dst_q) < LO) || (32'(dst_q) > HI) ||
                (src_q != ASZ'(SRC_ID)) ||
                (red_q != calc_redun(src_q, dst_q, dat_q)) ||
                (dat_q != exp_q);
    end

    always_ff @(posedge src0_clk or negedge reset) begin
      if (!reset) begin
        st_q  <= K_IDLE;
        src_q <= '0;
        dst_q <= '0;
        dat_q <= '0;
        red_q <= '0;
        exp_q <= '0;
        err_q <= 1'b0;
      end else begin
        st_q <= st_d;
        if (st_q == K_LATCH) begin
          src_q <= i_src[k*ASZ +: ASZ];
          dst_q <= i_dst[k*ASZ +: ASZ];
          dat_q <= i_dat[k*DSZ +: DSZ];
          red_q <= i_red[k*RSZ +: RSZ];
        end
        // Resync to the received value so a single bad datum costs one error.
        if (st_q == K_CHECK) begin
          exp_q <= dat_q + 1'b1;
          if (chk_err) err_q <= 1'b1;
        end
      end
    end

`ifdef IO_1TON_ERR_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge src0_clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= 8'h00;
      end else if (st_q == K_CHECK && chk_err && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'h01;
      end
    end

    assign err_cnt[k*8 +: 8] = cnt_q;
`else
    assign err_cnt[k*8 +: 8] = 8'h00;
`endif
  end

endmodule
